// File: rtl/ram_req_scheduler.sv
// Main-RAM port scheduler: arbitrates CPU and DMA requests onto a single SDRAM
// controller port, injects periodic refresh and guards each transaction with a watchdog.
module ram_req_scheduler #(
   parameter int REFRESH_CYCLES = 780,
   parameter int RFSH_HOLD      = 8,
   parameter int DMA_STREAK_MAX = 4,
   parameter int TIMEOUT        = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cpu_req,
   input  logic        cpu_rnw,
   input  logic [26:0] cpu_addr,
   input  logic [3:0]  cpu_be,
   input  logic [31:0] cpu_di,
   input  logic        cpu_iscache,
   output logic        cpu_ack,
   output logic        cpu_done,
   input  logic        dma_req,
   input  logic [26:0] dma_addr,
   input  logic [1:0]  dma_cnt,
   output logic        dma_ack,
   output logic        dma_done,
   output logic        ram_req,
   output logic [26:0] ram_addr,
   output logic        ram_rnw,
   output logic [3:0]  ram_be,
   output logic [31:0] ram_di,
   output logic        ram_iscache,
   output logic        ram_dma,
   output logic [1:0]  ram_dmacnt,
   output logic        ram_refresh,
   input  logic        ram_done,
   output logic        busy,
   output logic        err_timeout
);

   localparam int RCW = $clog2(2 * REFRESH_CYCLES);
   localparam int HW  = $clog2(RFSH_HOLD + 1);
   localparam int SW  = $clog2(DMA_STREAK_MAX + 1);

   localparam logic [RCW-1:0] RC_DUE     = RCW'(REFRESH_CYCLES);
   localparam logic [RCW-1:0] RC_SAT     = RCW'(2 * REFRESH_CYCLES - 1);
   localparam logic [HW-1:0]  HOLD_LAST  = HW'(RFSH_HOLD);
   localparam logic [SW-1:0]  STREAK_MAX = SW'(DMA_STREAK_MAX);
   localparam logic [7:0]     WDOG_LAST  = 8'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RFSH  = 2'd3
   } state_t;

   state_t         state;
   state_t         state_nx;
   logic [RCW-1:0] rcnt;
   logic [HW-1:0]  hcnt;
   logic [7:0]     wdog;
   logic [SW-1:0]  streak;
   logic           owner_dma;

   logic refresh_go;
   logic grant_dma;
   logic grant_cpu;
   logic finish;
   logic expire;

   // Next-state and per-cycle decisions; refresh outranks grants, DMA outranks CPU
   // unless the DMA streak has used up its allowance while the CPU waits.
   always_comb begin
      state_nx   = state;
      refresh_go = 1'b0;
      grant_dma  = 1'b0;
      grant_cpu  = 1'b0;
      finish     = 1'b0;
      expire     = 1'b0;
      case (state)
         IDLE: begin
            if (rcnt >= RC_DUE) begin
               refresh_go = 1'b1;
               state_nx   = RFSH;
            end else if (dma_req && !(cpu_req && (streak >= STREAK_MAX))) begin
               grant_dma = 1'b1;
               state_nx  = ISSUE;
            end else if (cpu_req) begin
               grant_cpu = 1'b1;
               state_nx  = ISSUE;
            end else begin
               state_nx = IDLE;
            end
         end
         ISSUE: begin
            state_nx = WAIT;
         end
         WAIT: begin
            if (ram_done) begin
               finish   = 1'b1;
               state_nx = IDLE;
            end else if (wdog == WDOG_LAST) begin
               finish   = 1'b1;
               expire   = 1'b1;
               state_nx = IDLE;
            end else begin
               state_nx = WAIT;
            end
         end
         RFSH: begin
            if (hcnt == HOLD_LAST) begin
               state_nx = IDLE;
            end else begin
               state_nx = RFSH;
            end
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Refresh interval counter; keeps running in every state so a refresh that
   // falls due mid-transaction is remembered and taken at the next IDLE.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rcnt <= '0;
      end else if (refresh_go) begin
         rcnt <= rcnt - RC_DUE + RCW'(1);
      end else if (rcnt != RC_SAT) begin
         rcnt <= rcnt + RCW'(1);
      end
   end

   // Refresh hold counter and completion watchdog, both restart from zero on entry.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hcnt <= '0;
         wdog <= 8'd0;
      end else begin
         hcnt <= (state == RFSH) ? hcnt + HW'(1) : '0;
         wdog <= (state == WAIT) ? wdog + 8'd1 : 8'd0;
      end
   end

   // DMA streak tracking: only consecutive DMA wins against a waiting CPU count.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         streak <= '0;
      end else if (grant_dma) begin
         if (!cpu_req) begin
            streak <= '0;
         end else if (streak >= STREAK_MAX) begin
            streak <= STREAK_MAX;
         end else begin
            streak <= streak + SW'(1);
         end
      end else if (grant_cpu) begin
         streak <= '0;
      end
   end

   // Capture the winning requester's fields at grant; they stay stable until the next grant.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         owner_dma   <= 1'b0;
         ram_addr    <= 27'd0;
         ram_rnw     <= 1'b0;
         ram_be      <= 4'd0;
         ram_di      <= 32'd0;
         ram_iscache <= 1'b0;
         ram_dma     <= 1'b0;
         ram_dmacnt  <= 2'd0;
      end else if (grant_dma) begin
         owner_dma   <= 1'b1;
         ram_addr    <= dma_addr;
         ram_rnw     <= 1'b1;
         ram_be      <= 4'd0;
         ram_di      <= 32'd0;
         ram_iscache <= 1'b0;
         ram_dma     <= 1'b1;
         ram_dmacnt  <= dma_cnt;
      end else if (grant_cpu) begin
         owner_dma   <= 1'b0;
         ram_addr    <= cpu_addr;
         ram_rnw     <= cpu_rnw;
         ram_be      <= cpu_be;
         ram_di      <= cpu_di;
         ram_iscache <= cpu_iscache;
         ram_dma     <= 1'b0;
         ram_dmacnt  <= 2'd0;
      end
   end

   // Strobes and status; each strobe is high for exactly the cycle after its decision.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ram_req     <= 1'b0;
         cpu_ack     <= 1'b0;
         dma_ack     <= 1'b0;
         ram_refresh <= 1'b0;
         cpu_done    <= 1'b0;
         dma_done    <= 1'b0;
         busy        <= 1'b0;
         err_timeout <= 1'b0;
      end else begin
         ram_req     <= grant_dma | grant_cpu;
         cpu_ack     <= grant_cpu;
         dma_ack     <= grant_dma;
         ram_refresh <= refresh_go;
         cpu_done    <= finish & ~owner_dma;
         dma_done    <= finish & owner_dma;
         busy        <= (state_nx != IDLE);
         err_timeout <= err_timeout | expire;
      end
   end

endmodule

// File: tb/tb_ram_req_scheduler.sv
// Self-checking bench for ram_req_scheduler: random CPU/DMA traffic and a randomized
// controller against a cycle-stepped behavioural model, plus directed timing scenarios.
module tb_ram_req_scheduler;

   localparam int RC   = 780;
   localparam int HOLD = 8;
   localparam int SMAX = 4;
   localparam int TMO  = 255;

   localparam int P_IDLE  = 0;
   localparam int P_ISSUE = 1;
   localparam int P_WAIT  = 2;
   localparam int P_RFSH  = 3;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        cpu_req, cpu_rnw, cpu_iscache, dma_req, ram_done;
   logic [26:0] cpu_addr, dma_addr;
   logic [3:0]  cpu_be;
   logic [31:0] cpu_di;
   logic [1:0]  dma_cnt;
   logic        cpu_ack, cpu_done, dma_ack, dma_done, ram_req, ram_rnw;
   logic        ram_iscache, ram_dma, ram_refresh, busy, err_timeout;
   logic [26:0] ram_addr;
   logic [3:0]  ram_be;
   logic [31:0] ram_di;
   logic [1:0]  ram_dmacnt;

   ram_req_scheduler dut (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_rnw(cpu_rnw), .cpu_addr(cpu_addr), .cpu_be(cpu_be),
      .cpu_di(cpu_di), .cpu_iscache(cpu_iscache), .cpu_ack(cpu_ack), .cpu_done(cpu_done),
      .dma_req(dma_req), .dma_addr(dma_addr), .dma_cnt(dma_cnt), .dma_ack(dma_ack),
      .dma_done(dma_done), .ram_req(ram_req), .ram_addr(ram_addr), .ram_rnw(ram_rnw),
      .ram_be(ram_be), .ram_di(ram_di), .ram_iscache(ram_iscache), .ram_dma(ram_dma),
      .ram_dmacnt(ram_dmacnt), .ram_refresh(ram_refresh), .ram_done(ram_done),
      .busy(busy), .err_timeout(err_timeout)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   // behavioural model state and expected outputs
   int          m_st, m_rcnt, m_left, m_waited, m_streak;
   bit          m_owner_dma;
   bit          e_cpu_ack, e_cpu_done, e_dma_ack, e_dma_done, e_ram_req, e_ram_refresh;
   bit          e_busy, e_err, e_rnw, e_iscache, e_dma;
   logic [26:0] e_addr;
   logic [3:0]  e_be;
   logic [31:0] e_di;
   logic [1:0]  e_dmacnt;

   // stimulus control and recorders
   bit          rand_on = 1'b0, hold_reqs = 1'b0, force_withhold = 1'b0;
   int          fixed_lat = 0, resp_cnt = 0;
   int          rf_q[$];
   int          last_req_cyc = -1, last_cpu_done_cyc = -1, last_dma_done_cyc = -1;
   int          n_req = 0, n_grants = 0;
   logic [9:0]  order = 10'd0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic model_reset();
      m_st = P_IDLE; m_rcnt = 0; m_left = 0; m_waited = 0; m_streak = 0; m_owner_dma = 1'b0;
      e_cpu_ack = 1'b0; e_cpu_done = 1'b0; e_dma_ack = 1'b0; e_dma_done = 1'b0;
      e_ram_req = 1'b0; e_ram_refresh = 1'b0; e_busy = 1'b0; e_err = 1'b0;
   endtask

   task automatic clear_inputs();
      cpu_req = 1'b0; cpu_rnw = 1'b0; cpu_addr = 27'd0; cpu_be = 4'd0; cpu_di = 32'd0;
      cpu_iscache = 1'b0; dma_req = 1'b0; dma_addr = 27'd0; dma_cnt = 2'd0; ram_done = 1'b0;
   endtask

   // Advance the model by one clock using the inputs currently applied.
   task automatic model_step();
      bit due, fin;
      int nx_rcnt;
      e_cpu_ack = 1'b0; e_dma_ack = 1'b0; e_ram_req = 1'b0; e_ram_refresh = 1'b0;
      e_cpu_done = 1'b0; e_dma_done = 1'b0; fin = 1'b0;
      due = (m_rcnt >= RC);
      nx_rcnt = (m_rcnt + 1 > 2 * RC - 1) ? 2 * RC - 1 : m_rcnt + 1;
      case (m_st)
         P_IDLE: begin
            if (due) begin
               nx_rcnt = m_rcnt - RC + 1;
               e_ram_refresh = 1'b1; m_left = HOLD + 1; m_st = P_RFSH;
            end else if (dma_req && !(cpu_req && m_streak >= SMAX)) begin
               e_dma_ack = 1'b1; e_ram_req = 1'b1; m_owner_dma = 1'b1; m_st = P_ISSUE;
               e_addr = dma_addr; e_rnw = 1'b1; e_iscache = 1'b0; e_dma = 1'b1; e_dmacnt = dma_cnt;
               m_streak = cpu_req ? ((m_streak + 1 > SMAX) ? SMAX : m_streak + 1) : 0;
            end else if (cpu_req) begin
               e_cpu_ack = 1'b1; e_ram_req = 1'b1; m_owner_dma = 1'b0; m_st = P_ISSUE;
               e_addr = cpu_addr; e_rnw = cpu_rnw; e_iscache = cpu_iscache; e_dma = 1'b0;
               e_be = cpu_be; e_di = cpu_di; m_streak = 0;
            end
         end
         P_ISSUE: begin
            m_st = P_WAIT; m_waited = 0;
         end
         P_WAIT: begin
            if (ram_done) begin
               fin = 1'b1;
            end else begin
               m_waited++;
               if (m_waited == TMO) begin
                  fin = 1'b1; e_err = 1'b1;
               end
            end
         end
         default: begin
            m_left--;
            if (m_left == 0) m_st = P_IDLE;
         end
      endcase
      if (fin) begin
         e_cpu_done = !m_owner_dma; e_dma_done = m_owner_dma; m_st = P_IDLE;
      end
      m_rcnt = nx_rcnt;
      e_busy = (m_st != P_IDLE);
   endtask

   task automatic compare_all();
      check_eq("cpu_ack", cpu_ack, e_cpu_ack);
      check_eq("cpu_done", cpu_done, e_cpu_done);
      check_eq("dma_ack", dma_ack, e_dma_ack);
      check_eq("dma_done", dma_done, e_dma_done);
      check_eq("ram_req", ram_req, e_ram_req);
      check_eq("ram_refresh", ram_refresh, e_ram_refresh);
      check_eq("busy", busy, e_busy);
      check_eq("err_timeout", err_timeout, e_err);
      if (e_ram_req) begin
         check_eq("ram_addr", ram_addr, e_addr);
         check_eq("ram_rnw", ram_rnw, e_rnw);
         check_eq("ram_dma", ram_dma, e_dma);
         check_eq("ram_iscache", ram_iscache, e_iscache);
         if (e_dma) begin
            check_eq("ram_dmacnt", ram_dmacnt, e_dmacnt);
         end else begin
            check_eq("ram_be", ram_be, e_be);
            check_eq("ram_di", ram_di, e_di);
         end
      end
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_outs"}, {cpu_ack, cpu_done, dma_ack, dma_done, ram_req, ram_rnw,
                               ram_iscache, ram_dma, ram_refresh, busy, err_timeout}, 64'd0);
      check_eq({tag, "_addr"}, ram_addr, 64'd0);
      check_eq({tag, "_data"}, {ram_be, ram_di, ram_dmacnt}, 64'd0);
   endtask

   // Controller model, requester behaviour and random traffic, applied after each edge.
   task automatic update_stimulus();
      ram_done = 1'b0;
      if (resp_cnt > 0) begin
         resp_cnt--;
         if (resp_cnt == 0) ram_done = 1'b1;
      end
      if (e_ram_req) begin
         if (force_withhold || (rand_on && $urandom_range(0, 99) == 0)) resp_cnt = 0;
         else resp_cnt = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 8));
      end
      if (rand_on && resp_cnt == 0 && !ram_done && $urandom_range(0, 30) == 0) ram_done = 1'b1;
      if (e_cpu_ack && !hold_reqs) cpu_req = 1'b0;
      if (e_dma_ack && !hold_reqs) dma_req = 1'b0;
      if (rand_on && !cpu_req && $urandom_range(0, 3) == 0) begin
         cpu_req = 1'b1; cpu_rnw = 1'($urandom); cpu_addr = 27'($urandom);
         cpu_be = 4'($urandom); cpu_di = $urandom; cpu_iscache = 1'($urandom);
      end
      if (rand_on && !dma_req && $urandom_range(0, 3) == 0) begin
         dma_req = 1'b1; dma_addr = 27'($urandom); dma_cnt = 2'($urandom);
      end
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      cyc++;
      compare_all();
      if (ram_refresh) rf_q.push_back(cyc);
      if (ram_req) begin
         last_req_cyc = cyc; n_req++; n_grants++; order = {order[8:0], ram_dma};
      end
      if (cpu_done) last_cpu_done_cyc = cyc;
      if (dma_done) last_dma_done_cyc = cyc;
      update_stimulus();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      clear_inputs();
      model_reset();
      resp_cnt = 0;
      repeat (2) @(posedge clk);
      #1;
      check_all_zero("rst");
      @(negedge clk);
      reset = 1'b0;
      cyc = 0;
   endtask

   initial begin
      clear_inputs();
      model_reset();
      do_reset();

      // Idle refresh cadence, then a DMA request arriving as the third refresh falls due
      repeat (2340) tick();
      dma_req = 1'b1; dma_addr = 27'($urandom); dma_cnt = 2'($urandom);
      n_req = 0;
      for (int i = 0; i < 40 && n_req == 0; i++) tick();
      check_eq("t3_rf_count", rf_q.size(), 64'd3);
      if (rf_q.size() >= 3) begin
         check_eq("t3_first_rf", rf_q[0], 64'd781);
         check_eq("t3_second_rf", rf_q[1], 64'd1561);
         check_eq("t4_rf", rf_q[2], 64'd2341);
      end
      check_eq("t4_dma_req_cyc", last_req_cyc, 64'd2351);
      repeat (30) tick();

      // Cache-line fill with a fixed controller latency
      do_reset();
      fixed_lat = 5; n_req = 0; last_cpu_done_cyc = -1;
      cpu_req = 1'b1; cpu_rnw = 1'b1; cpu_addr = 27'h0001000; cpu_iscache = 1'b1;
      cpu_be = 4'($urandom); cpu_di = $urandom;
      for (int i = 0; i < 40 && last_cpu_done_cyc < 0; i++) tick();
      check_eq("t1_req_count", n_req, 64'd1);
      check_eq("t1_done_delay", last_cpu_done_cyc - last_req_cyc, 64'd6);
      fixed_lat = 0;

      // Both requesters held: bounded DMA streak
      do_reset();
      hold_reqs = 1'b1; n_grants = 0; order = 10'd0;
      cpu_req = 1'b1; cpu_rnw = 1'b0; cpu_addr = 27'($urandom); cpu_be = 4'hF; cpu_di = $urandom;
      dma_req = 1'b1; dma_addr = 27'($urandom); dma_cnt = 2'd3;
      for (int i = 0; i < 2000 && n_grants < 10; i++) tick();
      check_eq("t2_grant_count", n_grants, 64'd10);
      check_eq("t2_grant_order", order, 64'h3DE);
      hold_reqs = 1'b0;

      // Random traffic, then drain
      rand_on = 1'b1;
      repeat (4000) tick();
      rand_on = 1'b0;
      repeat (300) tick();

      // Watchdog expiry on a DMA read
      do_reset();
      force_withhold = 1'b1; last_dma_done_cyc = -1;
      dma_req = 1'b1; dma_addr = 27'($urandom); dma_cnt = 2'($urandom);
      for (int i = 0; i < 400 && last_dma_done_cyc < 0; i++) tick();
      check_eq("t5_timeout_delay", last_dma_done_cyc - last_req_cyc, 64'd256);
      check_eq("t5_err_timeout", err_timeout, 64'd1);
      check_eq("t5_idle", busy, 64'd0);

      // Asynchronous reset in WAIT, then a late ram_done
      dma_req = 1'b1; dma_addr = 27'($urandom); dma_cnt = 2'($urandom);
      for (int i = 0; i < 20 && m_st != P_WAIT; i++) tick();
      repeat (3) tick();
      reset = 1'b1;
      #1;
      check_all_zero("t6");
      clear_inputs();
      model_reset();
      resp_cnt = 0; force_withhold = 1'b0;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0; cyc = 0;
      ram_done = 1'b1; last_dma_done_cyc = -1; last_cpu_done_cyc = -1;
      repeat (6) tick();
      check_eq("t6_no_done", {last_dma_done_cyc >= 0, last_cpu_done_cyc >= 0}, 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
